// File: rtl/player_input.sv
// player_input: merges PS/2 keys and MiSTer joysticks into per-player
// control vectors with autofire, coin pulse stretching and a pause toggle.
module player_input #(
   parameter int          NUM_PLAYERS     = 2,
   parameter int          NUM_BUTTONS     = 3,
   parameter logic [15:0] COIN_CYCLES     = 16'd50000,
   parameter int          AUTOFIRE_FRAMES = 2
) (
   input  logic                                   clk_sys,
   input  logic                                   RESET,
   input  logic [10:0]                            ps2_key,
   input  logic [16*NUM_PLAYERS-1:0]              joystick,
   input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0]     autofire_en,
   input  logic                                   frame,
   output logic [(NUM_BUTTONS+6)*NUM_PLAYERS-1:0] player,
   output logic                                   pause
);

   localparam int PW = NUM_BUTTONS + 6;
   localparam int FW = (AUTOFIRE_FRAMES > 1) ? $clog2(AUTOFIRE_FRAMES) : 1;
   localparam logic [FW-1:0] F_LAST = FW'(AUTOFIRE_FRAMES - 1);

   // Scan codes in order: up, down, left, right, b1..b6, start, coin
   localparam logic [7:0] P1_KEYS [12] = '{
      8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11,
      8'h29, 8'h12, 8'h1A, 8'h22, 8'h16, 8'h2E};
   localparam logic [7:0] P2_KEYS [12] = '{
      8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B,
      8'h15, 8'h1D, 8'h24, 8'h2C, 8'h1E, 8'h36};
   localparam logic [7:0] PAUSE_KEY = 8'h4D;

   // {valid, code} for output bit i of player p; only P1/P2 have keys
   function automatic logic [8:0] key_code(input int p, input int i);
      logic [3:0] k;
      if (i < 4 + NUM_BUTTONS)       k = 4'(i);
      else if (i == 4 + NUM_BUTTONS) k = 4'd10;
      else                           k = 4'd11;
      if (p == 0)      key_code = {1'b1, P1_KEYS[k]};
      else if (p == 1) key_code = {1'b1, P2_KEYS[k]};
      else             key_code = 9'd0;
   endfunction

   logic          primed;
   logic          old_toggle;
   logic          key_evt;
   logic          key_pause;
   logic [FW-1:0] fcnt;
   logic          af_phase;
   logic          pause_src;
   logic          pause_prev;
   logic          unused_ok;

   assign key_evt   = primed & (ps2_key[10] ^ old_toggle);
   assign unused_ok = ^{ps2_key[8], joystick};

   // First cycle after reset only samples the toggle; later flips are events
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         primed     <= 1'b0;
         old_toggle <= 1'b0;
      end else if (!primed) begin
         primed     <= 1'b1;
         old_toggle <= ps2_key[10];
      end else if (key_evt) begin
         old_toggle <= ps2_key[10];
      end
   end

   // Pause key state
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET)
         key_pause <= 1'b0;
      else if (key_evt && ps2_key[7:0] == PAUSE_KEY)
         key_pause <= ps2_key[9];
   end

   // Shared autofire phase, flips every AUTOFIRE_FRAMES frame strobes
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         fcnt     <= '0;
         af_phase <= 1'b1;
      end else if (frame) begin
         if (fcnt == F_LAST) begin
            fcnt     <= '0;
            af_phase <= ~af_phase;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end
   end

   // Pause request from the key or any player's joystick
   always_comb begin
      pause_src = key_pause;
      for (int p = 0; p < NUM_PLAYERS; p++)
         pause_src = pause_src | joystick[16*p + 6 + NUM_BUTTONS];
   end

   // Pause toggles once per rising edge of the merged request
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         pause_prev <= 1'b0;
         pause      <= 1'b0;
      end else begin
         pause_prev <= pause_src;
         if (pause_src && !pause_prev)
            pause <= ~pause;
      end
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
      logic [PW-1:0] key_r;
      logic [PW-1:0] src;
      logic [PW-1:0] out_r;
      logic          coin_prev;
      logic [15:0]   cnt;
      logic [15:0]   cnt_next;

      // Key registers laid out like the output vector
      always_ff @(posedge clk_sys or posedge RESET) begin
         if (RESET) begin
            key_r <= '0;
         end else if (key_evt) begin
            for (int i = 0; i < PW; i++)
               if (key_code(p, i) == {1'b1, ps2_key[7:0]})
                  key_r[i] <= ps2_key[9];
         end
      end

      // Merge keys with the joystick word, reordered to output layout
      always_comb begin
         src = key_r | {joystick[16*p + 5 + NUM_BUTTONS],
                        joystick[16*p + 4 + NUM_BUTTONS],
                        joystick[16*p + 4 +: NUM_BUTTONS],
                        joystick[16*p + 0],
                        joystick[16*p + 1],
                        joystick[16*p + 2],
                        joystick[16*p + 3]};
      end

      // Coin pulse counter; edges during an active pulse are dropped
      always_comb begin
         cnt_next = '0;
         if (cnt != '0)
            cnt_next = cnt - 16'd1;
         else if (src[PW-1] && !coin_prev)
            cnt_next = COIN_CYCLES;
      end

      // Registered player outputs with autofire gating on the buttons
      always_ff @(posedge clk_sys or posedge RESET) begin
         if (RESET) begin
            cnt       <= '0;
            coin_prev <= 1'b0;
            out_r     <= '0;
         end else begin
            cnt       <= cnt_next;
            coin_prev <= src[PW-1];
            out_r     <= {cnt_next != '0,
                          src[PW-2],
                          src[4 +: NUM_BUTTONS] &
                          (~autofire_en[p*NUM_BUTTONS +: NUM_BUTTONS] |
                           {NUM_BUTTONS{af_phase}}),
                          src[3:0]};
         end
      end

      assign player[PW*p +: PW] = out_r;
   end

endmodule

// File: tb/tb_player_input.sv
// tb_player_input: directed plan checks plus a randomized run against
// a behavioural model of keys, coin pulses, autofire and pause.
module tb_player_input;

   localparam int NP = 4;
   localparam int NB = 3;
   localparam int C  = 4;
   localparam int AF = 2;
   localparam int PW = NB + 6;

   localparam logic [7:0] K1 [12] = '{
      8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11,
      8'h29, 8'h12, 8'h1A, 8'h22, 8'h16, 8'h2E};
   localparam logic [7:0] K2 [12] = '{
      8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B,
      8'h15, 8'h1D, 8'h24, 8'h2C, 8'h1E, 8'h36};

   logic               clk_sys = 1'b0;
   logic               RESET;
   logic [10:0]        ps2_key;
   logic [16*NP-1:0]   joystick;
   logic [NP*NB-1:0]   autofire_en;
   logic               frame;
   logic [PW*NP-1:0]   player;
   logic               pause;

   player_input #(
      .NUM_PLAYERS(NP), .NUM_BUTTONS(NB),
      .COIN_CYCLES(16'(C)), .AUTOFIRE_FRAMES(AF)
   ) dut (
      .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key),
      .joystick(joystick), .autofire_en(autofire_en), .frame(frame),
      .player(player), .pause(pause)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_err    = 0;

   // model state
   int          cyc = 0;
   bit          m_primed, m_old;
   bit [11:0]   mkey [2];
   bit          mkey_pause;
   int          m_frames;
   bit          m_pause, m_prev_psrc;
   int          last_coin [NP];
   bit          prev_coin [NP];
   bit          coin_hi [NP];
   logic [PW*NP-1:0] exp_player;
   logic        exp_pause;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_primed = 0; m_old = 0;
      mkey[0] = '0; mkey[1] = '0; mkey_pause = 0;
      m_frames = 0; m_pause = 0; m_prev_psrc = 0;
      for (int p = 0; p < NP; p++) begin
         last_coin[p] = -100; prev_coin[p] = 0; coin_hi[p] = 0;
      end
   endtask

   // outputs expected after the coming clock edge, given current inputs
   task automatic model_step();
      logic [15:0] j;
      bit [8:0]    s;
      bit          phase, psrc;
      if (RESET) begin
         model_reset();
         exp_player = '0; exp_pause = 0; cyc++;
         return;
      end
      phase = ((m_frames / AF) % 2) == 0;
      psrc = mkey_pause;
      for (int p = 0; p < NP; p++) psrc |= joystick[16*p + 9];
      for (int p = 0; p < NP; p++) begin
         j = joystick[16*p +: 16];
         s = {j[8], j[7], j[6:4], j[0], j[1], j[2], j[3]};
         if (p < 2) begin
            for (int i = 0; i < 4 + NB; i++) s[i] |= mkey[p][i];
            s[7] |= mkey[p][10];
            s[8] |= mkey[p][11];
         end
         for (int i = 0; i < 4; i++) exp_player[PW*p + i] = s[i];
         for (int b = 0; b < NB; b++)
            exp_player[PW*p + 4 + b] =
               s[4+b] && (!autofire_en[NB*p + b] || phase);
         exp_player[PW*p + 7] = s[7];
         if (s[8] && !prev_coin[p] && !coin_hi[p]) last_coin[p] = cyc;
         coin_hi[p] = cyc >= last_coin[p] && cyc < last_coin[p] + C;
         prev_coin[p] = s[8];
         exp_player[PW*p + 8] = coin_hi[p];
      end
      if (psrc && !m_prev_psrc) m_pause = !m_pause;
      m_prev_psrc = psrc;
      exp_pause = m_pause;
      if (frame) m_frames++;
      if (!m_primed) begin
         m_primed = 1; m_old = ps2_key[10];
      end else if (ps2_key[10] != m_old) begin
         m_old = ps2_key[10];
         for (int k = 0; k < 12; k++) begin
            if (ps2_key[7:0] == K1[k]) mkey[0][k] = ps2_key[9];
            if (ps2_key[7:0] == K2[k]) mkey[1][k] = ps2_key[9];
         end
         if (ps2_key[7:0] == 8'h4D) mkey_pause = ps2_key[9];
      end
      cyc++;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("player", 64'(player), 64'(exp_player));
      chk("pause", 64'(pause), 64'(exp_pause));
   endtask

   task automatic kb(input bit pressed, input logic [7:0] code);
      ps2_key = {~ps2_key[10], pressed, 1'b0, code};
   endtask

   initial begin
      int cnt, first, b1cnt;
      logic [7:0] code;
      RESET = 1; ps2_key = {1'b1, 1'b1, 1'b0, 8'h16};
      joystick = '0; autofire_en = '0; frame = 0;
      model_reset();
      repeat (3) tick();
      chk("rst_player", 64'(player), 64'd0);
      chk("rst_pause", 64'(pause), 64'd0);

      // priming: toggle held high through release must not press start
      RESET = 0;
      repeat (3) tick();
      chk("prime_start", 64'(player[7]), 64'd0);
      kb(1, 8'h16);
      tick();
      chk("start_lat1", 64'(player[7]), 64'd0);
      tick();
      chk("start_on", 64'(player[7]), 64'd1);

      // keyboard up press/release and an unmapped code
      kb(1, 8'h75);
      tick();
      chk("up_lat1", 64'(player[0]), 64'd0);
      tick();
      chk("up_on", 64'(player[0]), 64'd1);
      kb(0, 8'h75);
      repeat (2) tick();
      chk("up_off", 64'(player[0]), 64'd0);
      kb(1, 8'h3C);
      repeat (2) tick();
      chk("unmapped", 64'(player), 64'h080);
      kb(0, 8'h16);
      repeat (2) tick();

      // autofire on P1 b2, b1 held without autofire
      joystick[4] = 1; joystick[5] = 1; autofire_en = 12'h002;
      cnt = 0; b1cnt = 0;
      for (int t = 1; t <= 80; t++) begin
         frame = (t % 10 == 0);
         tick();
         cnt += int'(player[5]);
         b1cnt += int'(player[4]);
         if (t == 20) chk("af_t20", 64'(player[5]), 64'd1);
         if (t == 21) chk("af_t21", 64'(player[5]), 64'd0);
      end
      chk("af_b2_high", 64'(cnt), 64'd40);
      chk("af_b1_high", 64'(b1cnt), 64'd80);
      frame = 0; joystick = '0; autofire_en = '0;
      tick();

      // P2 coin held for 20 cycles
      joystick[24] = 1;
      cnt = 0; first = -1;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (player[17]) begin
            cnt++;
            if (first < 0) first = t;
         end
      end
      chk("coin_len", 64'(cnt), 64'(C));
      chk("coin_first", 64'(first), 64'd1);
      joystick[24] = 0;
      repeat (2) tick();

      // re-press inside the pulse adds nothing
      cnt = 0;
      joystick[24] = 1; tick(); cnt += int'(player[17]);
      tick(); cnt += int'(player[17]);
      joystick[24] = 0; tick(); cnt += int'(player[17]);
      joystick[24] = 1;
      for (int t = 4; t <= 12; t++) begin
         tick(); cnt += int'(player[17]);
      end
      chk("coin_repress", 64'(cnt), 64'(C));
      joystick[24] = 0;
      repeat (5) tick();

      // pause from P3 joystick, then keyboard, then both together
      joystick[41] = 1; tick();
      chk("pause_p3", 64'(pause), 64'd1);
      joystick[41] = 0; tick();
      kb(1, 8'h4D); tick();
      chk("pause_kb_lat", 64'(pause), 64'd1);
      tick();
      chk("pause_kb", 64'(pause), 64'd0);
      kb(0, 8'h4D); repeat (2) tick();
      kb(1, 8'h4D); tick();
      joystick[9] = 1;
      repeat (3) tick();
      chk("pause_both", 64'(pause), 64'd1);

      // async reset mid coin pulse with pause set
      joystick[8] = 1;
      repeat (2) tick();
      chk("pre_rst_coin", 64'(player[8]), 64'd1);
      #2 RESET = 1;
      #1;
      chk("async_player", 64'(player), 64'd0);
      chk("async_pause", 64'(pause), 64'd0);
      joystick = '0;
      repeat (2) tick();
      RESET = 0;
      cnt = 0;
      repeat (8) begin
         tick(); cnt += int'(player[8]);
      end
      chk("coin_no_resume", 64'(cnt), 64'd0);

      // randomized run against the model
      for (int t = 0; t < 1500; t++) begin
         RESET = ($urandom_range(0, 399) == 0);
         frame = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0)
            joystick[$urandom_range(0, 16*NP-1)] ^= 1'b1;
         if ($urandom_range(0, 49) == 0)
            autofire_en = NP*NB'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 3))
               0: code = K1[$urandom_range(0, 11)];
               1: code = K2[$urandom_range(0, 11)];
               2: code = 8'h4D;
               default: code = 8'($urandom);
            endcase
            kb(1'($urandom), code);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
